shell_fire_controller: RTL and testbench
========================================

Name: shell_fire_controller

Overview:
Schedules tank shells for two players sharing one fixed pool of shell slots. Once per frame it:
- arbitrates fire requests into free slots,
- spawns each granted shell at the requesting tank's barrel position and facing,
- advances every live shell and retires it at the screen edge.

Sits between the player input/barrel-position logic and the colour mapper and collision logic, which consume the per-slot shell positions.

Parameters:
NUM_SHELLS, 4, number of shared shell slots (2..8)
SHELL_SPEED, 4, pixels moved per frame by a live shell
COOLDOWN_FRAMES, 15, frames a player is blocked after a grant
X_MAX, 639, largest legal shell X
Y_MAX, 479, largest legal shell Y

Ports:
Reset  input  1  asynchronous, active-high reset
frame_clk  input  1  clock, one rising edge per video frame
fire_req  input  2  per-player fire button level; bit p = player p
p0_barrel_x, p0_barrel_y  input  10 each  player 0 barrel centre
p0_dir  input  2  player 0 facing: 00 left, 01 right, 10 down, 11 up
p1_barrel_x, p1_barrel_y  input  10 each  player 1 barrel centre
p1_dir  input  2  player 1 facing, same encoding as p0_dir
shell_active  output  NUM_SHELLS  slot i live
shell_x  output  10*NUM_SHELLS  slot i X in bits [10i+9:10i]
shell_y  output  10*NUM_SHELLS  slot i Y in bits [10i+9:10i]
shell_owner  output  NUM_SHELLS  slot i owner (0/1)
fire_grant  output  2  one-frame pulse, player p's shot allocated
cooldown_busy  output  2  player p cooldown counter nonzero

Behaviour:
- Reset (any time, including mid-flight) clears all of the following:
  - shell_active, shell_x, shell_y, shell_owner
  - fire_grant, cooldown counters, pending flags
  - fire_req history; round-robin pointer to player 0.
- Edge detect: fire_req_q is the registered previous fire_req.
  - pending[p] sets when fire_req[p] & ~fire_req_q[p].
  - pending[p] clears on grant, or whenever fire_req[p] is low.
  - Holding the button therefore fires once.
- eligible[p] = pending[p] & (cooldown[p]==0).
- Free slots are evaluated from shell_active at the start of the frame. A slot retiring this frame is not reusable until the next frame.
- Allocation:
  - One eligible player takes the lowest-index free slot.
  - Both eligible with ≥2 free slots: player 0 gets the lowest free slot, player 1 the next.
  - Both eligible with exactly 1 free slot: the round-robin pointer's player wins. The pointer then flips to the other player; the loser stays pending.
  - Pointer changes only on contested grants.
  - No free slot: nothing granted; pending held.
- On grant (registered, effective on the same edge):
  - the slot loads x/y/dir from the owner's barrel inputs, and shell_active=1;
  - shell_owner=p, fire_grant[p]=1 for exactly that frame;
  - cooldown[p]=COOLDOWN_FRAMES.
- Spawned shells do not move on their spawn edge; the first move is on the next edge.
- Cooldown decrements by 1 per frame while nonzero and saturates at 0. cooldown_busy = (cooldown != 0).
- Movement per live slot per edge, using stored dir:
  - left: if x < SHELL_SPEED, retire; else x -= SHELL_SPEED.
  - right: if x + SHELL_SPEED > X_MAX (11-bit compare), retire; else x += SHELL_SPEED.
  - up/down: same rules on y against 0 / Y_MAX.
  - Retire clears shell_active only; x/y hold their last value.
- Inactive slots hold all fields. Barrel inputs matter only on grant edges.
- Latency: request edge seen at edge N, granted at edge N+1 at earliest (pending is registered), and visible at N+1.

Decomposition:
- Shared package tank_pkg holds:
  - dir_t enum: DIR_LEFT=2'b00, DIR_RIGHT=2'b01, DIR_DOWN=2'b10, DIR_UP=2'b11;
  - screen constants X_MAX and Y_MAX;
  - coord_t (10-bit).
- Sub-module shell_slot holds one slot's registers (active, x, y, dir, owner), spawn load, movement and edge retirement. The controller instantiates it NUM_SHELLS times and keeps the arbitration, pending and cooldown logic at top level.

Test Plan:
- P0 at (100,200), dir=01, press held 3 frames:
  - fire_grant[0] pulses once;
  - slot0 active at x=100, then 104, 108;
  - cooldown_busy[0] high for 15 frames.
- P0 presses again at frame 5 after a grant, still held: no grant until cooldown=0, then granted the following frame.
- Both press in the same frame, 4 slots free: P0→slot0, P1→slot1, both fire_grant bits pulse together.
- Three slots live, both press:
  - first contest P0 wins;
  - after P0's shell retires, P1 wins the next contest while still held.
- Slot with dir=00 at x=2: retires next edge with shell_active=0 and x stays 2. Slot dir=01 at x=636: retires; at x=635 it moves to 639.
- Four live shells, Reset asserted mid-frame asynchronously: all outputs zero immediately; the next press after Reset falls is granted into slot0.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared tank-game types: facing direction, screen coordinates and screen limits.
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef logic [9:0] coord_t;

    localparam int X_MAX = 639;
    localparam int Y_MAX = 479;

endpackage

// File: rtl/shell_fire_controller_if.sv
// Player-side and renderer-side signals of the shell fire controller.
interface shell_fire_controller_if #(
    parameter int NUM_SHELLS = 4
);
    import tank_pkg::*;

    // Handshake: fire_req is a level per player; fire_grant[p] is a one-frame
    // pulse on the edge the shot took a slot. A level held high fires only once.
    logic [1:0]              fire_req;
    coord_t                  p0_barrel_x;
    coord_t                  p0_barrel_y;
    logic [1:0]              p0_dir;
    coord_t                  p1_barrel_x;
    coord_t                  p1_barrel_y;
    logic [1:0]              p1_dir;

    logic [NUM_SHELLS-1:0]    shell_active;
    logic [10*NUM_SHELLS-1:0] shell_x;
    logic [10*NUM_SHELLS-1:0] shell_y;
    logic [NUM_SHELLS-1:0]    shell_owner;
    logic [1:0]               fire_grant;
    logic [1:0]               cooldown_busy;

    modport master (
        output fire_req, p0_barrel_x, p0_barrel_y, p0_dir,
               p1_barrel_x, p1_barrel_y, p1_dir,
        input  shell_active, shell_x, shell_y, shell_owner,
               fire_grant, cooldown_busy
    );

    modport slave (
        input  fire_req, p0_barrel_x, p0_barrel_y, p0_dir,
               p1_barrel_x, p1_barrel_y, p1_dir,
        output shell_active, shell_x, shell_y, shell_owner,
               fire_grant, cooldown_busy
    );

endinterface

// File: rtl/shell_fire_controller_slot.sv
// One shell slot: loads on spawn, steps each frame, retires at the screen edge.
module shell_slot
    import tank_pkg::*;
#(
    parameter int SHELL_SPEED = 4,
    parameter int X_LIMIT     = X_MAX,
    parameter int Y_LIMIT     = Y_MAX
) (
    input  logic   frame_clk,
    input  logic   Reset,
    input  logic   spawn,
    input  coord_t spawn_x,
    input  coord_t spawn_y,
    input  dir_t   spawn_dir,
    input  logic   spawn_owner,
    output logic   active,
    output coord_t x,
    output coord_t y,
    output logic   owner
);

    localparam coord_t      STEP    = coord_t'(SHELL_SPEED);
    localparam logic [10:0] STEP_W  = 11'(SHELL_SPEED);
    localparam logic [10:0] X_LIM_W = 11'(X_LIMIT);
    localparam logic [10:0] Y_LIM_W = 11'(Y_LIMIT);

    dir_t        dir;
    logic [10:0] x_fwd;
    logic [10:0] y_fwd;

    // One extra bit so a step past the right/bottom edge cannot wrap.
    assign x_fwd = {1'b0, x} + STEP_W;
    assign y_fwd = {1'b0, y} + STEP_W;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
            dir    <= DIR_LEFT;
            owner  <= 1'b0;
        end else if (spawn) begin
            active <= 1'b1;
            x      <= spawn_x;
            y      <= spawn_y;
            dir    <= spawn_dir;
            owner  <= spawn_owner;
        end else if (active) begin
            case (dir)
                DIR_LEFT:  if (x < STEP)         active <= 1'b0; else x <= x - STEP;
                DIR_RIGHT: if (x_fwd > X_LIM_W)  active <= 1'b0; else x <= x_fwd[9:0];
                DIR_UP:    if (y < STEP)         active <= 1'b0; else y <= y - STEP;
                DIR_DOWN:  if (y_fwd > Y_LIM_W)  active <= 1'b0; else y <= y_fwd[9:0];
            endcase
        end
    end

endmodule

// File: rtl/shell_fire_controller.sv
// Per-frame shell scheduler: edge-detects fire buttons, arbitrates free slots
// between two players with cooldown, and drives the shared slot array.
module shell_fire_controller #(
    parameter int NUM_SHELLS      = 4,
    parameter int SHELL_SPEED     = 4,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int X_MAX           = tank_pkg::X_MAX,
    parameter int Y_MAX           = tank_pkg::Y_MAX
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    shell_fire_controller_if.slave  bus
);
    import tank_pkg::coord_t;
    import tank_pkg::dir_t;

    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    localparam int SW = $clog2(NUM_SHELLS);

    logic [1:0]            fire_req_q;
    logic [1:0]            pending;
    logic [CW-1:0]         cooldown [2];
    logic                  rr_ptr;
    logic [1:0]            fire_grant_q;

    logic [1:0]            eligible;
    logic [1:0]            grant;
    logic                  rr_flip;
    logic [NUM_SHELLS-1:0] free_slots;
    logic                  found0, found1;
    logic [SW-1:0]         idx0, idx1;
    logic [SW-1:0]         slot_p0, slot_p1;
    logic [NUM_SHELLS-1:0] spawn;
    logic [NUM_SHELLS-1:0] spawn_owner;

    logic [NUM_SHELLS-1:0] slot_active;
    logic [NUM_SHELLS-1:0] slot_owner;
    coord_t                slot_x [NUM_SHELLS];
    coord_t                slot_y [NUM_SHELLS];

    assign eligible[0] = pending[0] & (cooldown[0] == '0);
    assign eligible[1] = pending[1] & (cooldown[1] == '0);
    // Slots retiring on this edge stay unavailable until the next frame.
    assign free_slots  = ~slot_active;

    always_comb begin
        found0 = 1'b0;
        found1 = 1'b0;
        idx0   = '0;
        idx1   = '0;
        for (int i = 0; i < NUM_SHELLS; i++) begin
            if (free_slots[i]) begin
                if (!found0) begin
                    found0 = 1'b1;
                    idx0   = SW'(i);
                end else if (!found1) begin
                    found1 = 1'b1;
                    idx1   = SW'(i);
                end
            end
        end
    end

    always_comb begin
        grant   = 2'b00;
        slot_p0 = idx0;
        slot_p1 = idx0;
        rr_flip = 1'b0;
        case (eligible)
            2'b01: grant[0] = found0;
            2'b10: grant[1] = found0;
            2'b11: begin
                if (found1) begin
                    grant   = 2'b11;
                    slot_p1 = idx1;
                end else if (found0) begin
                    // Single contested slot: pointer's player wins, pointer flips.
                    rr_flip = 1'b1;
                    if (rr_ptr) grant[1] = 1'b1;
                    else        grant[0] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        spawn       = '0;
        spawn_owner = '0;
        for (int i = 0; i < NUM_SHELLS; i++) begin
            spawn[i]       = (grant[0] && (slot_p0 == SW'(i))) ||
                             (grant[1] && (slot_p1 == SW'(i)));
            spawn_owner[i] = grant[1] && (slot_p1 == SW'(i));
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            fire_req_q   <= 2'b00;
            pending      <= 2'b00;
            cooldown[0]  <= '0;
            cooldown[1]  <= '0;
            rr_ptr       <= 1'b0;
            fire_grant_q <= 2'b00;
        end else begin
            fire_req_q   <= bus.fire_req;
            pending      <= bus.fire_req & (~fire_req_q | (pending & ~grant));
            rr_ptr       <= rr_flip ? ~rr_ptr : rr_ptr;
            fire_grant_q <= grant;
            for (int p = 0; p < 2; p++) begin
                if (grant[p])                cooldown[p] <= CW'(COOLDOWN_FRAMES);
                else if (cooldown[p] != '0)  cooldown[p] <= cooldown[p] - 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_SHELLS; i++) begin : g_slot
        shell_slot #(
            .SHELL_SPEED (SHELL_SPEED),
            .X_LIMIT     (X_MAX),
            .Y_LIMIT     (Y_MAX)
        ) u_slot (
            .frame_clk   (frame_clk),
            .Reset       (Reset),
            .spawn       (spawn[i]),
            .spawn_x     (spawn_owner[i] ? bus.p1_barrel_x : bus.p0_barrel_x),
            .spawn_y     (spawn_owner[i] ? bus.p1_barrel_y : bus.p0_barrel_y),
            .spawn_dir   (spawn_owner[i] ? dir_t'(bus.p1_dir) : dir_t'(bus.p0_dir)),
            .spawn_owner (spawn_owner[i]),
            .active      (slot_active[i]),
            .x           (slot_x[i]),
            .y           (slot_y[i]),
            .owner       (slot_owner[i])
        );
    end

    always_comb begin
        bus.shell_x = '0;
        bus.shell_y = '0;
        for (int i = 0; i < NUM_SHELLS; i++) begin
            bus.shell_x[10*i +: 10] = slot_x[i];
            bus.shell_y[10*i +: 10] = slot_y[i];
        end
    end

    assign bus.shell_active     = slot_active;
    assign bus.shell_owner      = slot_owner;
    assign bus.fire_grant       = fire_grant_q;
    assign bus.cooldown_busy[0] = (cooldown[0] != '0);
    assign bus.cooldown_busy[1] = (cooldown[1] != '0);

endmodule

// File: tb/tb_shell_fire_controller.sv
// Directed bench for shell_fire_controller with hand-computed expectations.
module tb_shell_fire_controller;

  logic frame_clk;
  logic Reset;
  int   checks;
  int   errors;
  logic [31:0] exp_q[$];

  shell_fire_controller_if #(.NUM_SHELLS(4)) bus ();

  shell_fire_controller #(.NUM_SHELLS(4)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx(input int i);
    return 32'(bus.shell_x[10*i +: 10]);
  endfunction

  function automatic logic [31:0] sy(input int i);
    return 32'(bus.shell_y[10*i +: 10]);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_active"}, 32'(bus.shell_active), 0);
    check({tag, "_x"},      32'(bus.shell_x), 0);
    check({tag, "_y"},      32'(bus.shell_y), 0);
    check({tag, "_owner"},  32'(bus.shell_owner), 0);
    check({tag, "_grant"},  32'(bus.fire_grant), 0);
    check({tag, "_busy"},   32'(bus.cooldown_busy), 0);
  endtask

  // Asserts Reset mid-frame, checks outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    #2;
    Reset = 1'b1;
    bus.fire_req = 2'b00;
    #1;
    check_all_zero(tag);
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    bus.fire_req = 2'b00;
    bus.p0_barrel_x = '0; bus.p0_barrel_y = '0; bus.p0_dir = 2'b00;
    bus.p1_barrel_x = '0; bus.p1_barrel_y = '0; bus.p1_dir = 2'b00;
    tick();
    tick();
    check_all_zero("reset");
    Reset = 1'b0;

    // Single player, right-moving shell, held button, cooldown.
    bus.p0_barrel_x = 100; bus.p0_barrel_y = 200; bus.p0_dir = 2'b01;
    bus.fire_req = 2'b01;
    exp_q.push_back(100); exp_q.push_back(104); exp_q.push_back(108);
    tick();
    check("a1_grant", 32'(bus.fire_grant), 0);
    check("a1_active", 32'(bus.shell_active), 0);
    tick();
    check("a2_grant", 32'(bus.fire_grant), 1);
    check("a2_active", 32'(bus.shell_active), 1);
    check("a2_owner", 32'(bus.shell_owner), 0);
    check("a2_y0", sy(0), 200);
    check("a2_busy", 32'(bus.cooldown_busy), 1);
    check("a2_x0", sx(0), exp_q.pop_front());
    tick();
    check("a3_grant", 32'(bus.fire_grant), 0);
    check("a3_x0", sx(0), exp_q.pop_front());
    bus.fire_req = 2'b00;
    tick();
    check("a4_x0", sx(0), exp_q.pop_front());
    for (int n = 5; n <= 17; n++) begin
      tick();
      check("b_grant_blocked", 32'(bus.fire_grant), 0);
      check("b_busy", 32'(bus.cooldown_busy), (n <= 16) ? 1 : 0);
      if (n == 6) bus.fire_req = 2'b01;
    end
    tick();
    check("b18_grant", 32'(bus.fire_grant), 1);
    check("b18_active", 32'(bus.shell_active), 3);
    check("b18_x1", sx(1), 100);
    check("b18_busy", 32'(bus.cooldown_busy), 1);
    async_reset("rst_a");

    // Both players, four free slots.
    bus.p0_barrel_x = 100; bus.p0_barrel_y = 200; bus.p0_dir = 2'b01;
    bus.p1_barrel_x = 300; bus.p1_barrel_y = 400; bus.p1_dir = 2'b00;
    bus.fire_req = 2'b11;
    tick();
    check("c1_grant", 32'(bus.fire_grant), 0);
    tick();
    check("c2_grant", 32'(bus.fire_grant), 3);
    check("c2_active", 32'(bus.shell_active), 3);
    check("c2_owner", 32'(bus.shell_owner), 2);
    check("c2_x0", sx(0), 100);
    check("c2_x1", sx(1), 300);
    check("c2_y1", sy(1), 400);
    bus.fire_req = 2'b00;
    tick();
    check("c3_x0", sx(0), 104);
    check("c3_x1", sx(1), 296);
    async_reset("rst_c");

    // Right-edge boundary: 635 steps to 639, 636 retires.
    bus.p0_barrel_x = 635; bus.p0_barrel_y = 50; bus.p0_dir = 2'b01;
    bus.p1_barrel_x = 636; bus.p1_barrel_y = 60; bus.p1_dir = 2'b01;
    bus.fire_req = 2'b11;
    tick();
    tick();
    check("e2_active", 32'(bus.shell_active), 3);
    bus.fire_req = 2'b00;
    tick();
    check("e3_active", 32'(bus.shell_active), 1);
    check("e3_x0", sx(0), 639);
    check("e3_x1", sx(1), 636);
    tick();
    check("e4_active", 32'(bus.shell_active), 0);
    check("e4_x0", sx(0), 639);
    async_reset("rst_e");

    // Contention for a single free slot, left-edge retirement at x=2.
    bus.p0_barrel_x = 202; bus.p0_barrel_y = 100; bus.p0_dir = 2'b00;
    bus.p1_barrel_x = 50;  bus.p1_barrel_y = 0;   bus.p1_dir = 2'b10;
    bus.fire_req = 2'b11;
    tick();
    tick();
    check("d2_grant", 32'(bus.fire_grant), 3);
    bus.fire_req = 2'b00;
    bus.p0_barrel_x = 0; bus.p0_barrel_y = 300; bus.p0_dir = 2'b01;
    for (int n = 3; n <= 53; n++) begin
      tick();
      check("d_grant", 32'(bus.fire_grant), (n == 18 || n == 34) ? 1 : 0);
      check("d_active", 32'(bus.shell_active),
            (n < 18) ? 3 : (n < 34) ? 7 : (n < 53) ? 15 : 14);
      if (n == 10) check("d10_y1", sy(1), 32);
      if (n == 18) check("d18_x2", sx(2), 0);
      if (n == 52) check("d52_x0", sx(0), 2);
      if (n == 53) begin
        check("d53_x0", sx(0), 2);
        check("d53_owner", 32'(bus.shell_owner), 2);
      end
      if (n == 3)  bus.fire_req = 2'b01;
      if (n == 18) bus.fire_req = 2'b00;
      if (n == 32) begin
        bus.fire_req = 2'b11;
        bus.p0_barrel_x = 0; bus.p0_barrel_y = 310;
      end
      if (n == 34) begin
        bus.fire_req = 2'b10;
        bus.p1_barrel_x = 400; bus.p1_barrel_y = 20; bus.p1_dir = 2'b00;
      end
      if (n == 36) bus.fire_req = 2'b11;
    end
    tick();
    check("d54_grant", 32'(bus.fire_grant), 2);
    check("d54_active", 32'(bus.shell_active), 15);
    check("d54_owner", 32'(bus.shell_owner), 3);
    check("d54_x0", sx(0), 400);
    check("d54_y0", sy(0), 20);
    check("d54_y1", sy(1), 208);
    check("d54_x3", sx(3), 80);
    async_reset("rst_d");

    // First press after reset lands in slot 0.
    bus.p0_barrel_x = 10; bus.p0_barrel_y = 20; bus.p0_dir = 2'b11;
    bus.fire_req = 2'b01;
    tick();
    check("f1_grant", 32'(bus.fire_grant), 0);
    tick();
    check("f2_grant", 32'(bus.fire_grant), 1);
    check("f2_active", 32'(bus.shell_active), 1);
    check("f2_x0", sx(0), 10);
    check("f2_y0", sy(0), 20);
    tick();
    check("f3_y0", sy(0), 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
